// File: rtl/hash_key_loader_if.sv
// Byte-stream key input, lookup3 key/hash connection and result hand-off
// between the key parser, the hash key loader and the lookup3 core.
interface hash_key_loader_if;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;

  logic [7:0]  key_length;
  logic [31:0] k0;
  logic [31:0] k1;
  logic [31:0] k2;
  logic        key_valid;
  logic [31:0] hashkey;

  logic [31:0] res_hash;
  logic [7:0]  res_len;
  logic        res_overflow;
  logic        res_valid;
  logic        res_ready;

  // Loader side: consumes bytes and hash, produces key and result.
  modport master (
    input  s_data, s_valid, s_last, hashkey, res_ready,
    output s_ready, key_length, k0, k1, k2, key_valid,
           res_hash, res_len, res_overflow, res_valid
  );

  // Environment side: parser, lookup3 core and result consumer.
  modport slave (
    output s_data, s_valid, s_last, hashkey, res_ready,
    input  s_ready, key_length, k0, k1, k2, key_valid,
           res_hash, res_len, res_overflow, res_valid
  );
endinterface

// File: rtl/hash_key_loader.sv
// Packs a byte-stream key (up to 12 bytes) into lookup3 k0..k2, waits a fixed
// hash latency, captures the hash and holds the result until it is taken.
module hash_key_loader #(
  parameter int unsigned HASH_LATENCY = 4
) (
  input  logic               CLK,
  input  logic               RST,
  hash_key_loader_if.master  bus
);

  localparam int unsigned KEY_BYTES = 12;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned KEY_W     = KEY_BYTES * BYTE_W;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned WCNT_W    = 8;
  localparam int unsigned LEN_W     = 8;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [WORD_W-1:0]   res_hash_q, res_hash_d;
  logic [LEN_W-1:0]    res_len_q, res_len_d;
  logic                res_ovf_q, res_ovf_d;
  logic                res_valid_q, res_valid_d;
  logic                s_ready_q, s_ready_d;
  logic                key_valid_q, key_valid_d;
  logic                accept_c;

  // s_ready_q is only ever high in FILL, so it alone qualifies a beat.
  assign accept_c = bus.s_valid && s_ready_q;

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_FILL;
      key_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      wcnt_q      <= '0;
      res_hash_q  <= '0;
      res_len_q   <= '0;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
      s_ready_q   <= 1'b0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      wcnt_q      <= wcnt_d;
      res_hash_q  <= res_hash_d;
      res_len_q   <= res_len_d;
      res_ovf_q   <= res_ovf_d;
      res_valid_q <= res_valid_d;
      s_ready_q   <= s_ready_d;
      key_valid_q <= key_valid_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    wcnt_d     = wcnt_q;
    res_hash_d = res_hash_q;
    res_len_d  = res_len_q;
    res_ovf_d  = res_ovf_q;

    unique case (state_q)
      ST_FILL: begin
        if (accept_c) begin
          if (cnt_q < CNT_W'(KEY_BYTES)) begin
            // Byte i lands in word i/4, most significant lane first.
            for (int unsigned b = 0; b < KEY_BYTES; b++) begin
              if (cnt_q == CNT_W'(b)) begin
                key_d[KEY_W-1-BYTE_W*b -: BYTE_W] = bus.s_data;
              end
            end
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
          if (bus.s_last) begin
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        wcnt_d  = WCNT_W'(HASH_LATENCY);
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        wcnt_d = wcnt_q - WCNT_W'(1);
        if (wcnt_q == WCNT_W'(1)) begin
          res_hash_d = bus.hashkey;
          res_len_d  = LEN_W'(cnt_q);
          res_ovf_d  = ovf_q;
          state_d    = ST_DONE;
        end
      end

      ST_DONE: begin
        if (bus.res_ready) begin
          key_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_FILL;
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase

    // Handshake outputs follow the state being entered.
    s_ready_d   = (state_d == ST_FILL);
    key_valid_d = (state_d == ST_ISSUE);
    res_valid_d = (state_d == ST_DONE);
  end

  assign bus.s_ready      = s_ready_q;
  assign bus.key_valid    = key_valid_q;
  assign bus.key_length   = LEN_W'(cnt_q);
  assign bus.k0           = key_q[KEY_W-1          -: WORD_W];
  assign bus.k1           = key_q[KEY_W-1-WORD_W   -: WORD_W];
  assign bus.k2           = key_q[KEY_W-1-2*WORD_W -: WORD_W];
  assign bus.res_hash     = res_hash_q;
  assign bus.res_len      = res_len_q;
  assign bus.res_overflow = res_ovf_q;
  assign bus.res_valid    = res_valid_q;

endmodule

// File: tb/tb_hash_key_loader.sv
// Self-checking bench for hash_key_loader: directed and random keys against a
// byte-array reference model, with a stub hasher that is valid only at T+L.
module tb_hash_key_loader;

  localparam int unsigned L = 4;

  typedef logic [7:0] bq_t[$];

  logic CLK = 1'b0;
  logic RST;

  hash_key_loader_if bus();

  hash_key_loader #(.HASH_LATENCY(L)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc     = 0;
  int unsigned hash_at = 32'hFFFF_FFFF;
  logic [31:0] magic   = 32'h0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Stub lookup3: the real hash is only present during cycle T+L.
  always @(negedge CLK) bus.hashkey = (cyc == hash_at) ? magic : 32'h0;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] e_k [3];
  logic [7:0]  e_len;
  logic [31:0] e_ovf;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bq_t str2q(input string s);
    bq_t q;
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Reference: byte i -> word i/4, shifted so byte 0 is the MSB.
  function automatic void model(input bq_t q);
    int n;
    n = q.size();
    for (int w = 0; w < 3; w++) e_k[w] = 32'h0;
    for (int i = 0; i < n && i < 12; i++)
      e_k[i/4] = e_k[i/4] | (32'(q[i]) << (24 - 8 * (i % 4)));
    e_len = 8'((n > 12) ? 12 : n);
    e_ovf = (n > 12) ? 32'd1 : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_key(input string tag);
    check({tag, "_k0"},  bus.k0, e_k[0]);
    check({tag, "_k1"},  bus.k1, e_k[1]);
    check({tag, "_k2"},  bus.k2, e_k[2]);
    check({tag, "_len"}, 32'(bus.key_length), 32'(e_len));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"},   32'(bus.s_ready), 32'd0);
    check({tag, "_key_valid"}, 32'(bus.key_valid), 32'd0);
    check({tag, "_k0"},        bus.k0, 32'd0);
    check({tag, "_k1"},        bus.k1, 32'd0);
    check({tag, "_k2"},        bus.k2, 32'd0);
    check({tag, "_key_len"},   32'(bus.key_length), 32'd0);
    check({tag, "_res_hash"},  bus.res_hash, 32'd0);
    check({tag, "_res_len"},   32'(bus.res_len), 32'd0);
    check({tag, "_res_ovf"},   32'(bus.res_overflow), 32'd0);
    check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input string tag, input logic [7:0] d, input logic last);
    int unsigned guard;
    guard = 0;
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    bus.s_last  = last;
    while (bus.s_ready !== 1'b1 && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    check({tag, "_ready_for_byte"}, 32'(bus.s_ready), 32'd1);
    @(negedge CLK);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  // Streams a key, returning in cycle T (the cycle after the last accept).
  task automatic stream_key(input string tag, input bq_t q, input int gap);
    int g;
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) begin
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        repeat (g) begin
          @(negedge CLK);
          check({tag, "_gap_len"},   32'(bus.key_length), 32'((i > 12) ? 12 : i));
          check({tag, "_gap_ready"}, 32'(bus.s_ready), 32'd1);
        end
      end
      send_byte(tag, q[i], (i == q.size() - 1));
    end
  endtask

  task automatic take_result(input string tag, input int hold, input logic [31:0] mg);
    bus.res_ready = 1'b0;
    repeat (hold) begin
      @(negedge CLK);
      check({tag, "_hold_valid"}, 32'(bus.res_valid), 32'd1);
      check({tag, "_hold_hash"},  bus.res_hash, mg);
      check({tag, "_hold_ready"}, 32'(bus.s_ready), 32'd0);
      check_key({tag, "_hold"});
    end
    bus.res_ready = 1'b1;
    @(negedge CLK);
    bus.res_ready = 1'b0;
    check({tag, "_rel_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_rel_ready"}, 32'(bus.s_ready), 32'd1);
    check({tag, "_rel_k0"},    bus.k0, 32'd0);
    check({tag, "_rel_k1"},    bus.k1, 32'd0);
    check({tag, "_rel_k2"},    bus.k2, 32'd0);
    check({tag, "_rel_len"},   32'(bus.key_length), 32'd0);
  endtask

  task automatic run_key(input string tag, input bq_t q, input int gap, input int hold,
                         input logic [31:0] mg, input bit noise);
    model(q);
    stream_key(tag, q, gap);
    hash_at = cyc + L;
    magic   = mg;
    check({tag, "_T_key_valid"}, 32'(bus.key_valid), 32'd1);
    check({tag, "_T_s_ready"},   32'(bus.s_ready), 32'd0);
    check({tag, "_T_res_valid"}, 32'(bus.res_valid), 32'd0);
    check_key({tag, "_T"});
    for (int c = 1; c <= int'(L); c++) begin
      @(negedge CLK);
      check({tag, "_wait_key_valid"}, 32'(bus.key_valid), 32'd0);
      check({tag, "_wait_res_valid"}, 32'(bus.res_valid), 32'd0);
      check_key({tag, "_wait"});
      if (noise) begin
        bus.s_valid = 1'($urandom_range(0, 1));
        bus.s_data  = 8'($urandom);
        bus.s_last  = 1'($urandom_range(0, 1));
      end
    end
    @(negedge CLK);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd1);
    check({tag, "_res_hash"},  bus.res_hash, mg);
    check({tag, "_res_len"},   32'(bus.res_len), 32'(e_len));
    check({tag, "_res_ovf"},   32'(bus.res_overflow), e_ovf);
    check({tag, "_done_ready"}, 32'(bus.s_ready), 32'd0);
    check_key({tag, "_done"});
    take_result(tag, hold, mg);
  endtask

  task automatic reset_mid_wait(input string tag, input bq_t q);
    model(q);
    stream_key(tag, q, 0);
    hash_at = cyc + L;
    magic   = $urandom;
    check({tag, "_T_key_valid"}, 32'(bus.key_valid), 32'd1);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check_all_zero({tag, "_in_rst"});
    @(negedge CLK);
    check_all_zero({tag, "_in_rst2"});
    RST = 1'b0;
    @(negedge CLK);
    check({tag, "_after_rst_ready"}, 32'(bus.s_ready), 32'd1);
    repeat (L + 2) begin
      @(negedge CLK);
      check({tag, "_no_res_valid"}, 32'(bus.res_valid), 32'd0);
      check({tag, "_no_res_hash"},  bus.res_hash, 32'd0);
    end
  endtask

  initial begin
    bq_t rq;
    int  n;
    RST           = 1'b1;
    bus.s_data    = 8'h0;
    bus.s_valid   = 1'b0;
    bus.s_last    = 1'b0;
    bus.res_ready = 1'b0;

    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b0;
    @(negedge CLK);
    check("post_reset_ready", 32'(bus.s_ready), 32'd1);

    run_key("short",    str2q("abcde"),          0, 0,  $urandom,     1'b0);
    run_key("full",     str2q("abcdefghijkl"),   0, 0,  32'hDEADBEEF, 1'b0);
    run_key("overflow", str2q("abcdefghijklmn"), 0, 1,  $urandom,     1'b1);
    run_key("backpr",   str2q("backpressure"),   0, 10, $urandom,     1'b1);
    run_key("gapped",   str2q("ab"),             3, 0,  $urandom,     1'b0);
    run_key("xyz",      str2q("xyz"),            0, 0,  $urandom,     1'b0);
    reset_mid_wait("rst_wait", str2q("abcdefg"));
    run_key("after_rst", str2q("q"),             0, 0,  $urandom,     1'b0);

    for (int k = 0; k < 12; k++) begin
      rq = {};
      n  = int'($urandom_range(1, 16));
      for (int i = 0; i < n; i++) rq.push_back(8'($urandom));
      run_key("rand", rq, -1, int'($urandom_range(0, 3)), $urandom, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
